// File: rtl/gravador_sequencia_memoria.sv
// Sequence-RAM writer: each rising edge of jogada stores chaves at the next address,
// walking addresses 0..N_ENDERECOS-1 once per session started by iniciar.
module gravador_sequencia_memoria #(
  parameter int N_ENDERECOS = 16,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada,
  input  logic [DATA_W-1:0] chaves,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_endereco,
  output logic [DATA_W-1:0] mem_dado,
  output logic              pronto,
  output logic [ADDR_W-1:0] db_endereco,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    INICIAL    = 4'h0,
    PREPARACAO = 4'h1,
    ESPERA     = 4'h2,
    REGISTRA   = 4'h3,
    GRAVA      = 4'h4,
    PROXIMO    = 4'h5,
    FIM        = 4'hF
  } estado_t;

  localparam logic [ADDR_W-1:0] ULTIMO = ADDR_W'(N_ENDERECOS - 1);

  estado_t           r_estado, w_prox;
  logic [ADDR_W-1:0] r_endereco;
  logic [DATA_W-1:0] r_dado;
  logic              r_jogada_d;
  logic              w_pulso;
  logic              w_zera, w_carrega, w_incrementa;

  // Edges are only consumed in ESPERA; elsewhere they are simply lost.
  assign w_pulso = jogada & ~r_jogada_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_jogada_d <= 1'b0;
    else        r_jogada_d <= jogada;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= INICIAL;
    else        r_estado <= w_prox;
  end

  always_comb begin
    w_prox       = INICIAL;
    w_zera       = 1'b0;
    w_carrega    = 1'b0;
    w_incrementa = 1'b0;
    mem_we       = 1'b0;
    pronto       = 1'b0;
    case (r_estado)
      INICIAL:    w_prox = iniciar ? PREPARACAO : INICIAL;
      PREPARACAO: begin
        w_zera = 1'b1;
        w_prox = ESPERA;
      end
      ESPERA:     w_prox = w_pulso ? REGISTRA : ESPERA;
      REGISTRA:   begin
        w_carrega = 1'b1;
        w_prox    = GRAVA;
      end
      GRAVA:      begin
        mem_we = 1'b1;
        // Last address exits before incrementing, so the counter never wraps.
        w_prox = (r_endereco == ULTIMO) ? FIM : PROXIMO;
      end
      PROXIMO:    begin
        w_incrementa = 1'b1;
        w_prox       = ESPERA;
      end
      FIM:        begin
        pronto = 1'b1;
        w_prox = iniciar ? PREPARACAO : FIM;
      end
      default:    w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)            r_endereco <= '0;
    else if (w_zera)       r_endereco <= '0;
    else if (w_incrementa) r_endereco <= r_endereco + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         r_dado <= '0;
    else if (w_zera)    r_dado <= '0;
    else if (w_carrega) r_dado <= chaves;
  end

  assign mem_endereco = r_endereco;
  assign mem_dado     = r_dado;
  assign db_endereco  = r_endereco;
  assign db_estado    = r_estado;

endmodule
